dart_launcher: RTL and testbench
================================

# dart_launcher

Stimulus-side partner of the dart scoring machine. It generates dart throws: a one-cycle `dart_come_o` pulse with a 10×10 board position. It then waits for the scorer's per-player done handshake and alternates players. It stops when the scorer reports game set, when a throw limit is reached, or when a protocol error occurs. It sits on the board/test side of the dart interface and drives the scorer's `dart_come_i` and `dart_position_{x,y}_i` inputs directly.

## Interface
- `SEED`, 8'hA5, LFSR load value. A value of 0 is replaced by 8'h01.
- `MAX_THROWS`, 10'd600, number of throws after which the game ends with no winner.
- `IDLE_GAP`, 2, cycles spent in GAP before each throw (≥1).
- `TIMEOUT`, 16, maximum cycles allowed in WAIT_DONE before ERROR (≥4).
- `clk`  in  1  clock. One clock domain, everything is posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start_i`  in  1  starts a game. Sampled only in IDLE, OVER and ERROR.
- `player_1_done_i`  in  1  scorer finished player 1's turn.
- `player_2_done_i`  in  1  scorer finished player 2's turn.
- `game_set_i`  in  1  scorer reports the game ended. Coincides with a done pulse.
- `player_1_win_i`  in  1  player 1 score is 0.
- `player_2_win_i`  in  1  player 2 score is 0.
- `dart_come_o`  out  1  one-cycle throw strobe.
- `dart_position_x_o`  out  4  x coordinate, range 0..9.
- `dart_position_y_o`  out  4  y coordinate, range 0..9.
- `busy_o`  out  1  high in GAP, THROW and WAIT_DONE.
- `turn_o`  out  1  expected player: 0 = player 1, 1 = player 2.
- `throws_o`  out  10  count of completed throws (done received).
- `winner_o`  out  2  01 = player 1, 10 = player 2, 00 = none. Valid in OVER.
- `error_o`  out  1  high while in ERROR.

## Operation
- States: IDLE, GAP, THROW, WAIT_DONE, OVER, ERROR.
- IDLE →(start_i) GAP. Entering GAP from IDLE, OVER or ERROR does all of the following:
  - LFSR ← SEED
  - throws_o ← 0
  - turn_o ← 0
  - winner_o ← 00
- GAP: counts IDLE_GAP cycles, then goes to THROW.
- THROW: lasts 1 cycle with dart_come_o = 1, then goes to WAIT_DONE. In the same cycle:
  - Positions are registered from the current LFSR value and held until the next THROW.
  - The LFSR advances one step.
- LFSR: 8-bit Fibonacci. next = {l[6:0], l[7]^l[5]^l[4]^l[3]}.
- Position mapping:
  - x = l[3:0], y = l[7:4].
  - Any nibble ≥ 10 maps to nibble − 10, so 10..15 → 0..5.
- WAIT_DONE, checked in priority order:
  1. The done input matching turn_o:
     - throws_o increments.
     - If game_set_i: latch winner_o = {player_2_win_i, player_1_win_i} → OVER.
     - Else if throws_o+1 == MAX_THROWS → OVER with winner 00.
     - Else toggle turn_o → GAP.
  2. The done input for the wrong player, or both dones at once → ERROR.
  3. Cycle counter reaches TIMEOUT → ERROR.
- Outside WAIT_DONE, done, game_set and win inputs are ignored.
- OVER and ERROR hold all outputs until start_i. start_i restarts via GAP.
- The scorer must be reset separately before a restart.
- start_i is ignored in GAP, THROW and WAIT_DONE.

## Timing
- Reset values: state IDLE, and every output 0, including positions, winner_o, throws_o and turn_o. LFSR = SEED.
- Reset asserted mid-game aborts at the next edge: no further dart_come_o pulse and no counter update.
- Start pulse at edge t: GAP occupies t+1 … t+IDLE_GAP, and dart_come_o is high in cycle t+IDLE_GAP+1.
- Positions become valid in the same cycle as dart_come_o and stay stable at least through the next cycle, because the scorer samples them one cycle after the strobe.
- Nominal scorer response: done arrives 3 cycles after the dart_come_o cycle. The timeout counter starts at 0 on entry to WAIT_DONE.
- Throw period with a nominal scorer: IDLE_GAP + 1 + 3 cycles.
- throws_o saturates logically at MAX_THROWS, because OVER is entered on reaching it.

## Test plan
- Seed check: SEED = A5, start, scorer model replies after 3 cycles.
  - Throw 1: (x, y) = (5, 0).
  - Throw 2: LFSR = 4A, (x, y) = (0, 4).
  - turn_o goes 0 → 1 → 0, and dart_come_o is exactly one cycle wide each throw.
- Game set: on the 7th done (player 1, turn_o = 0), assert game_set_i with player_1_win_i = 1.
  - Required: OVER, winner_o = 01, throws_o = 7, busy_o = 0, no further strobes.
- Wrong player: reply player_2_done_i while turn_o = 0.
  - Required: ERROR on the next cycle, error_o = 1, throws_o unchanged.
- Timeout: withhold done after a throw.
  - Required: ERROR exactly TIMEOUT cycles after WAIT_DONE entry.
  - Then start_i → GAP, throws_o = 0, error_o = 0.
- Throw limit: MAX_THROWS = 4, never assert game_set_i.
  - Required: OVER after the 4th done, winner_o = 00.
- Reset and ignored start: assert reset during WAIT_DONE.
  - Required: all outputs 0 next cycle, no strobe.
  - A start_i pulse during GAP has no effect on throw timing.

Source files
------------

// File: rtl/dart_launcher_if.sv
// Signal bundle between the dart launcher and the dart scoring machine.
// master = launcher side, slave = scorer/test side.
interface dart_launcher_if;
  logic       start_i;
  logic       player_1_done_i;
  logic       player_2_done_i;
  logic       game_set_i;
  logic       player_1_win_i;
  logic       player_2_win_i;
  logic       dart_come_o;
  logic [3:0] dart_position_x_o;
  logic [3:0] dart_position_y_o;
  logic       busy_o;
  logic       turn_o;
  logic [9:0] throws_o;
  logic [1:0] winner_o;
  logic       error_o;

  modport master (
    input  start_i, player_1_done_i, player_2_done_i, game_set_i,
           player_1_win_i, player_2_win_i,
    output dart_come_o, dart_position_x_o, dart_position_y_o, busy_o,
           turn_o, throws_o, winner_o, error_o
  );

  modport slave (
    output start_i, player_1_done_i, player_2_done_i, game_set_i,
           player_1_win_i, player_2_win_i,
    input  dart_come_o, dart_position_x_o, dart_position_y_o, busy_o,
           turn_o, throws_o, winner_o, error_o
  );
endinterface

// File: rtl/dart_launcher.sv
// Dart throw generator: LFSR-driven board positions, one strobe per throw,
// alternating players on the scorer's done handshake until game set, limit or error.
module dart_launcher #(
  parameter logic [7:0] SEED       = 8'hA5,
  parameter logic [9:0] MAX_THROWS = 10'd600,
  parameter int         IDLE_GAP   = 2,
  parameter int         TIMEOUT    = 16
) (
  input  logic           clk,
  input  logic           reset,
  dart_launcher_if.master dart
);
  typedef enum logic [2:0] {IDLE, GAP, THROW, WAIT_DONE, OVER, ERROR} state_t;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] GAP_LAST = 16'(IDLE_GAP - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [7:0]  lfsr;
  logic [3:0]  pos_x, pos_y;
  logic        turn;
  logic [9:0]  throws;
  logic [1:0]  winner;
  logic        do_restart, do_throw, do_accept;
  logic        match_done, wrong_done, both_done, at_limit;

  function automatic logic [3:0] fold_nibble(input logic [3:0] n);
    return (n >= 4'd10) ? n - 4'd10 : n;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  assign match_done = turn ? dart.player_2_done_i : dart.player_1_done_i;
  assign wrong_done = turn ? dart.player_1_done_i : dart.player_2_done_i;
  assign both_done  = dart.player_1_done_i & dart.player_2_done_i;
  assign at_limit   = (throws + 10'd1) == MAX_THROWS;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_restart = 1'b0;
    do_throw   = 1'b0;
    do_accept  = 1'b0;
    unique case (state)
      IDLE, OVER, ERROR: begin
        if (dart.start_i) begin
          state_nxt  = GAP;
          do_restart = 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = THROW;
          do_throw  = 1'b1;
        end
      end
      THROW: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (both_done) begin
          state_nxt = ERROR;
        end else if (match_done) begin
          do_accept = 1'b1;
          state_nxt = (dart.game_set_i || at_limit) ? OVER : GAP;
        end else if (wrong_done || cnt == TO_LAST) begin
          state_nxt = ERROR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Positions load on the GAP->THROW edge so they are valid during the strobe cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      lfsr   <= SEED_EFF;
      pos_x  <= '0;
      pos_y  <= '0;
      turn   <= 1'b0;
      throws <= '0;
      winner <= '0;
    end else begin
      cnt <= (state_nxt == state) ? cnt + 16'd1 : '0;
      if (do_restart) begin
        lfsr   <= SEED_EFF;
        throws <= '0;
        turn   <= 1'b0;
        winner <= '0;
      end
      if (do_throw) begin
        pos_x <= fold_nibble(lfsr[3:0]);
        pos_y <= fold_nibble(lfsr[7:4]);
        lfsr  <= lfsr_step(lfsr);
      end
      if (do_accept) begin
        throws <= throws + 10'd1;
        if (dart.game_set_i) winner <= {dart.player_2_win_i, dart.player_1_win_i};
        else if (!at_limit)  turn   <= ~turn;
      end
    end
  end

  assign dart.dart_come_o       = (state == THROW);
  assign dart.busy_o            = (state == GAP) || (state == THROW) || (state == WAIT_DONE);
  assign dart.error_o           = (state == ERROR);
  assign dart.dart_position_x_o = pos_x;
  assign dart.dart_position_y_o = pos_y;
  assign dart.turn_o            = turn;
  assign dart.throws_o          = throws;
  assign dart.winner_o          = winner;
endmodule

// File: tb/tb_dart_launcher.sv
// Scoreboard bench for dart_launcher: a scorer model replies to throws, and expected
// throws (position, player, cycle) are queued on start/done and checked on each strobe.
module tb_dart_launcher;
  localparam int IDLE_GAP = 2;
  localparam int TIMEOUT  = 16;

  typedef struct packed {
    logic [3:0]  x;
    logic [3:0]  y;
    logic        turn;
    logic [31:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         strobes = 0;
  int         lim_strobes = 0;
  logic       prev_come = 1'b0;
  logic [7:0] m_lfsr = 8'hA5;
  logic       m_turn = 1'b0;
  exp_t       sb[$];
  exp_t       last_e = '0;

  dart_launcher_if dif ();
  dart_launcher_if lif ();

  dart_launcher #(.SEED(8'hA5), .MAX_THROWS(10'd600), .IDLE_GAP(IDLE_GAP), .TIMEOUT(TIMEOUT))
    dut (.clk(clk), .reset(reset), .dart(dif));

  dart_launcher #(.SEED(8'hA5), .MAX_THROWS(10'd4), .IDLE_GAP(IDLE_GAP), .TIMEOUT(TIMEOUT))
    lim_dut (.clk(clk), .reset(reset), .dart(lif));

  assign lif.start_i         = dif.start_i;
  assign lif.player_1_done_i = dif.player_1_done_i;
  assign lif.player_2_done_i = dif.player_2_done_i;
  assign lif.game_set_i      = dif.game_set_i;
  assign lif.player_1_win_i  = dif.player_1_win_i;
  assign lif.player_2_win_i  = dif.player_2_win_i;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] fold(input logic [3:0] n);
    if (n > 4'd9) return n - 4'd10;
    return n;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    logic fb;
    fb = ^(l & 8'b1011_1000);
    return {l[6:0], fb};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_throw(input bit lit, input logic [3:0] lx, input logic [3:0] ly);
    exp_t n;
    n.x    = lit ? lx : fold(m_lfsr[3:0]);
    n.y    = lit ? ly : fold(m_lfsr[7:4]);
    n.turn = m_turn;
    n.cyc  = 32'(cyc + 1 + IDLE_GAP);
    sb.push_back(n);
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic start_game(input bit lit, input logic [3:0] lx, input logic [3:0] ly);
    @(negedge clk);
    dif.start_i = 1'b1;
    m_lfsr = 8'hA5;
    m_turn = 1'b0;
    push_throw(lit, lx, ly);
    @(negedge clk);
    dif.start_i = 1'b0;
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (dif.dart_come_o) ok = 1'b1;
    end
    check("strobe_seen", 32'(ok), 32'd1);
  endtask

  // Scorer model: answers 3 cycles after the strobe cycle.
  task automatic reply(input bit wrong, input bit gs, input bit lit,
                       input logic [3:0] lx, input logic [3:0] ly);
    repeat (3) @(negedge clk);
    if (m_turn ^ wrong) dif.player_2_done_i = 1'b1;
    else                dif.player_1_done_i = 1'b1;
    dif.game_set_i     = gs;
    dif.player_1_win_i = gs & ~m_turn;
    dif.player_2_win_i = gs & m_turn;
    if (!wrong && !gs) begin
      m_turn = ~m_turn;
      push_throw(lit, lx, ly);
    end
    @(negedge clk);
    dif.player_1_done_i = 1'b0;
    dif.player_2_done_i = 1'b0;
    dif.game_set_i      = 1'b0;
    dif.player_1_win_i  = 1'b0;
    dif.player_2_win_i  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_come"},   32'(dif.dart_come_o), 32'd0);
    check({tag, "_x"},      32'(dif.dart_position_x_o), 32'd0);
    check({tag, "_y"},      32'(dif.dart_position_y_o), 32'd0);
    check({tag, "_busy"},   32'(dif.busy_o), 32'd0);
    check({tag, "_turn"},   32'(dif.turn_o), 32'd0);
    check({tag, "_throws"}, 32'(dif.throws_o), 32'd0);
    check({tag, "_winner"}, 32'(dif.winner_o), 32'd0);
    check({tag, "_error"},  32'(dif.error_o), 32'd0);
  endtask

  always @(negedge clk) begin
    if (prev_come) begin
      check("pos_hold_x", 32'(dif.dart_position_x_o), 32'(last_e.x));
      check("pos_hold_y", 32'(dif.dart_position_y_o), 32'(last_e.y));
    end
    if (dif.dart_come_o) begin
      strobes++;
      check("come_width", 32'(prev_come), 32'd0);
      if (sb.size() == 0) begin
        check("strobe_expected", 32'(dif.dart_come_o), 32'd0);
      end else begin
        last_e = sb.pop_front();
        check("pos_x", 32'(dif.dart_position_x_o), 32'(last_e.x));
        check("pos_y", 32'(dif.dart_position_y_o), 32'(last_e.y));
        check("turn",  32'(dif.turn_o), 32'(last_e.turn));
        check("strobe_cycle", 32'(cyc), last_e.cyc);
      end
    end
    if (lif.dart_come_o) lim_strobes++;
    prev_come = dif.dart_come_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int n;
    dif.start_i         = 1'b0;
    dif.player_1_done_i = 1'b0;
    dif.player_2_done_i = 1'b0;
    dif.game_set_i      = 1'b0;
    dif.player_1_win_i  = 1'b0;
    dif.player_2_win_i  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Game 1: seed check, ignored start in GAP, game set on the 7th done
    start_game(1'b1, 4'd5, 4'd0);
    for (int i = 1; i <= 7; i++) begin
      wait_strobe(ok);
      if (!ok) break;
      reply(1'b0, i == 7, i == 1, 4'd0, 4'd4);
      if (i == 2) begin
        dif.start_i = 1'b1;
        @(negedge clk);
        dif.start_i = 1'b0;
      end
      if (i == 4) begin
        check("lim_busy",   32'(lif.busy_o), 32'd0);
        check("lim_winner", 32'(lif.winner_o), 32'd0);
        check("lim_throws", 32'(lif.throws_o), 32'd4);
        check("lim_error",  32'(lif.error_o), 32'd0);
      end
    end
    check("over_busy",   32'(dif.busy_o), 32'd0);
    check("over_winner", 32'(dif.winner_o), 32'd1);
    check("over_throws", 32'(dif.throws_o), 32'd7);
    check("over_error",  32'(dif.error_o), 32'd0);
    check("over_turn",   32'(dif.turn_o), 32'd0);
    repeat (12) @(negedge clk);
    check("over_strobes",  32'(strobes), 32'd7);
    check("lim_strobes",   32'(lim_strobes), 32'd4);
    check("over_hold_win", 32'(dif.winner_o), 32'd1);
    check("sb_empty_1",    32'(sb.size()), 32'd0);

    // Game 2: wrong player on the 3rd throw
    start_game(1'b0, 4'd0, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      wait_strobe(ok);
      if (!ok) break;
      reply(i == 3, 1'b0, 1'b0, 4'd0, 4'd0);
    end
    check("wrong_error",  32'(dif.error_o), 32'd1);
    check("wrong_throws", 32'(dif.throws_o), 32'd2);
    check("wrong_busy",   32'(dif.busy_o), 32'd0);

    // Game 3: timeout, restart from ERROR
    start_game(1'b0, 4'd0, 4'd0);
    check("restart_busy",   32'(dif.busy_o), 32'd1);
    check("restart_throws", 32'(dif.throws_o), 32'd0);
    check("restart_error",  32'(dif.error_o), 32'd0);
    check("restart_turn",   32'(dif.turn_o), 32'd0);
    wait_strobe(ok);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dif.error_o) break;
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check("timeout_error",  32'(dif.error_o), 32'd1);
    check("timeout_throws", 32'(dif.throws_o), 32'd0);

    start_game(1'b0, 4'd0, 4'd0);
    check("restart2_busy",   32'(dif.busy_o), 32'd1);
    check("restart2_throws", 32'(dif.throws_o), 32'd0);
    check("restart2_error",  32'(dif.error_o), 32'd0);

    // Game 4: reset during WAIT_DONE after one completed throw
    wait_strobe(ok);
    reply(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    wait_strobe(ok);
    check("pre_reset_throws", 32'(dif.throws_o), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_strobes", 32'(strobes), 32'd13);
    check("post_reset_busy",    32'(dif.busy_o), 32'd0);
    check("sb_empty_end",       32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
